// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch unit: opcode encodings,
// opcode field position, FSM state type and the default reset address.
package fetch_pkg;

  localparam logic [2:0]  OPC_IMM          = 3'b001;
  localparam logic [2:0]  OPC_NOP          = 3'b101;
  localparam int unsigned OPC_MSB          = 15;
  localparam int unsigned OPC_LSB          = 13;
  localparam int unsigned DEFAULT_RESET_PC = 32;

  typedef enum logic {
    FETCH_OP  = 1'b0,
    FETCH_IMM = 1'b1
  } fetch_state_e;

  function automatic logic [2:0] opc_of(input logic [15:0] word);
    return word[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Bundle of the instruction-memory read port, the decode-side packet
// handshake and the redirect request seen by the fetch unit.
interface inst_fetch_unit_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned INST_W = 16
);

  logic [ADDR_W-1:0] imem_addr;
  logic              imem_rd_en;
  logic [INST_W-1:0] imem_data;
  logic              out_valid;
  logic              out_ready;
  logic [INST_W-1:0] out_inst;
  logic [INST_W-1:0] out_imm;
  logic              out_has_imm;
  logic              redirect_en;
  logic [ADDR_W-1:0] redirect_pc;

  modport master (
    output imem_addr, imem_rd_en, out_valid, out_inst, out_imm, out_has_imm,
    input  imem_data, out_ready, redirect_en, redirect_pc
  );

  modport slave (
    input  imem_addr, imem_rd_en, out_valid, out_inst, out_imm, out_has_imm,
    output imem_data, out_ready, redirect_en, redirect_pc
  );

endinterface

// File: rtl/fetch_pc.sv
// Program counter: reset load, redirect load, otherwise +1 per consumed word
// (wraps modulo 2^ADDR_W).
module fetch_pc #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect_en_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  input  logic              inc_en_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_q;

  // PC register; reset outranks redirect, redirect outranks increment
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q <= RESET_PC;
    end else if (redirect_en_i) begin
      pc_q <= redirect_pc_i;
    end else if (inc_en_i) begin
      pc_q <= pc_q + ADDR_W'(1);
    end else begin
      pc_q <= pc_q;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: reads one word per cycle at the PC and assembles
// one-word or opcode+immediate packets for decode behind a valid/ready register.
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INST_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic               clk,
  input  logic               reset,
  inst_fetch_unit_if.master  bus
);

  fetch_state_e      state_q, state_d;
  logic [INST_W-1:0] op_q, op_d;
  logic              valid_q, valid_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [INST_W-1:0] imm_q, imm_d;
  logic              has_imm_q, has_imm_d;
  logic              adv_s;
  logic              rd_en_s;
  logic [ADDR_W-1:0] pc_s;

  // Output register free, or being drained by decode this cycle
  assign adv_s   = !valid_q || bus.out_ready;
  assign rd_en_s = adv_s && !bus.redirect_en && reset;

  fetch_pc #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_fetch_pc (
    .clk           (clk),
    .reset         (reset),
    .redirect_en_i (bus.redirect_en),
    .redirect_pc_i (bus.redirect_pc),
    .inc_en_i      (rd_en_s),
    .pc_o          (pc_s)
  );

  // State, op latch and packet register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= FETCH_OP;
      op_q      <= {INST_W{1'b0}};
      valid_q   <= 1'b0;
      inst_q    <= {INST_W{1'b0}};
      imm_q     <= {INST_W{1'b0}};
      has_imm_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      valid_q   <= valid_d;
      inst_q    <= inst_d;
      imm_q     <= imm_d;
      has_imm_q <= has_imm_d;
    end
  end

  // Next-state: redirect drops any half-built or pending packet
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    valid_d   = valid_q;
    inst_d    = inst_q;
    imm_d     = imm_q;
    has_imm_d = has_imm_q;
    if (bus.redirect_en) begin
      state_d = FETCH_OP;
      valid_d = 1'b0;
    end else if (adv_s) begin
      case (state_q)
        FETCH_OP: begin
          if (opc_of(bus.imem_data) == OPC_IMM) begin
            op_d    = bus.imem_data;
            state_d = FETCH_IMM;
            valid_d = 1'b0;
          end else begin
            inst_d    = bus.imem_data;
            imm_d     = {INST_W{1'b0}};
            has_imm_d = 1'b0;
            valid_d   = 1'b1;
          end
        end
        FETCH_IMM: begin
          inst_d    = op_q;
          imm_d     = bus.imem_data;
          has_imm_d = 1'b1;
          valid_d   = 1'b1;
          state_d   = FETCH_OP;
        end
        default: begin
          state_d = FETCH_OP;
          valid_d = 1'b0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  assign bus.imem_addr   = pc_s;
  assign bus.imem_rd_en  = rd_en_s;
  assign bus.out_valid   = valid_q;
  assign bus.out_inst    = inst_q;
  assign bus.out_imm     = imm_q;
  assign bus.out_has_imm = has_imm_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit: an instruction-stream parser predicts
// the packet sequence from any start PC; a negedge monitor checks handshakes.
module tb_inst_fetch_unit;

  typedef struct packed {
    logic [15:0] inst;
    logic [15:0] imm;
    logic        has;
  } pkt_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  inst_fetch_unit_if #(.ADDR_W(32), .INST_W(16)) bus ();

  inst_fetch_unit #(
    .ADDR_W   (32),
    .INST_W   (16),
    .RESET_PC (32'd32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [15:0] mem [256];
  assign bus.imem_data = mem[bus.imem_addr[7:0]];

  pkt_t exp_q[$];
  int   checks  = 0;
  int   passed  = 0;
  int   pkt_cnt = 0;
  logic stall_pend = 1'b0;
  pkt_t stall_pkt;
  logic found;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference: parse the instruction stream from start; LDM (top bits 001) takes the next word
  task automatic refill(input logic [31:0] start);
    logic [31:0] p;
    logic [31:0] p1;
    logic [15:0] w;
    pkt_t        k;
    exp_q.delete();
    p = start;
    for (int n = 0; n < 300; n++) begin
      w = mem[p[7:0]];
      if (w[15:13] == 3'b001) begin
        p1 = p + 32'd1;
        k = '{inst: w, imm: mem[p1[7:0]], has: 1'b1};
        p = p + 32'd2;
      end else begin
        k = '{inst: w, imm: 16'h0000, has: 1'b0};
        p = p + 32'd1;
      end
      exp_q.push_back(k);
    end
  endtask

  task automatic load_program();
    mem[32] = 16'h2800; mem[33] = 16'h000F; mem[34] = 16'hA800;
    mem[35] = 16'h2BE0; mem[36] = 16'h000D;
  endtask

  // Call just after a rising edge; memory may be edited before finish_redirect
  task automatic start_redirect(input logic [31:0] pc);
    bus.redirect_en = 1'b1;
    bus.redirect_pc = pc;
  endtask

  task automatic finish_redirect(input logic [31:0] pc);
    @(negedge clk);
    chk("redirect_rd_en", bus.imem_rd_en, 1'b0);
    #1 refill(pc);
    @(posedge clk);
    #1 bus.redirect_en = 1'b0;
    @(negedge clk);
    chk("redirect_valid", bus.out_valid, 1'b0);
    chk("redirect_addr", bus.imem_addr, pc);
    chk("redirect_next_rd", bus.imem_rd_en, 1'b1);
  endtask

  // Monitor: transfers, and stability of a stalled packet
  always @(negedge clk) begin
    pkt_t cur;
    cur = '{inst: bus.out_inst, imm: bus.out_imm, has: bus.out_has_imm};
    if (stall_pend) chk("hold_stable", {bus.out_valid, cur}, {1'b1, stall_pkt});
    if (reset && bus.out_valid && bus.out_ready) begin
      pkt_cnt++;
      chk("exp_available", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) chk("packet", cur, exp_q.pop_front());
    end
    stall_pend <= reset && bus.out_valid && !bus.out_ready && !bus.redirect_en;
    stall_pkt  <= cur;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.out_ready   = 1'b1;
    bus.redirect_en = 1'b0;
    bus.redirect_pc = 32'd0;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    load_program();

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", bus.out_valid, 1'b0);
    chk("rst_fields", {bus.out_inst, bus.out_imm, bus.out_has_imm}, 33'd0);
    chk("rst_addr", bus.imem_addr, 32'd32);
    chk("rst_rd_en", bus.imem_rd_en, 1'b0);
    refill(32'd32);
    @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("addr_step", bus.imem_addr, 32'd32 + 32'(i));
      chk("valid_timing", bus.out_valid, (i == 2 || i == 3));
    end

    // Stall while the NOP packet is presented
    @(posedge clk); #1;
    start_redirect(32'd32);
    finish_redirect(32'd32);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid && bus.out_inst == 16'hA800) begin
        bus.out_ready = 1'b0;
        found = 1'b1;
      end
    end
    chk("stall_reached", found, 1'b1);
    repeat (3) begin
      @(negedge clk);
      chk("stall_pkt", {bus.out_valid, bus.out_inst, bus.out_has_imm}, {1'b1, 16'hA800, 1'b0});
      chk("stall_addr", bus.imem_addr, 32'd35);
      chk("stall_rd_en", bus.imem_rd_en, 1'b0);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(negedge clk);
    chk("resume_rd_en", {bus.imem_rd_en, bus.imem_addr}, {1'b1, 32'd35});
    @(negedge clk);
    chk("resume_mid", {bus.out_valid, bus.imem_addr}, {1'b0, 32'd36});
    @(negedge clk);
    chk("resume_pkt", {bus.out_valid, bus.out_inst, bus.out_imm, bus.out_has_imm},
        {1'b1, 16'h2BE0, 16'h000D, 1'b1});

    // Redirect while waiting for an immediate
    @(posedge clk); #1;
    start_redirect(32'd50);
    mem[50] = 16'h2800; mem[51] = 16'h0055; mem[40] = 16'h1111; mem[41] = 16'hA800;
    finish_redirect(32'd50);
    @(posedge clk); #1;
    chk("in_fetch_imm", {bus.out_valid, bus.imem_addr}, {1'b0, 32'd51});
    start_redirect(32'd40);
    finish_redirect(32'd40);
    repeat (4) @(negedge clk);

    // Immediate instruction at the top address wraps to 0
    @(posedge clk); #1;
    start_redirect(32'hFFFF_FFFF);
    mem[255] = 16'h2800; mem[0] = 16'h1234;
    finish_redirect(32'hFFFF_FFFF);
    @(negedge clk);
    chk("wrap_mid", {bus.out_valid, bus.imem_addr}, {1'b0, 32'd0});
    @(negedge clk);
    chk("wrap_pkt", {bus.out_valid, bus.out_inst, bus.out_imm, bus.out_has_imm},
        {1'b1, 16'h2800, 16'h1234, 1'b1});
    chk("wrap_pc", bus.imem_addr, 32'd1);

    // Back-to-back NOPs: one packet per cycle
    @(posedge clk); #1;
    start_redirect(32'd200);
    for (int i = 200; i < 220; i++) mem[i] = 16'hA800;
    finish_redirect(32'd200);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("nop_stream", {bus.out_valid, bus.out_inst, bus.out_imm, bus.out_has_imm},
          {1'b1, 16'hA800, 16'h0000, 1'b0});
    end

    // Random memory, random backpressure, random redirects
    @(posedge clk); #1;
    start_redirect(32'd64);
    for (int i = 0; i < 256; i++) begin
      mem[i] = 16'($urandom);
      if ($urandom_range(0, 2) == 0) mem[i][15:13] = 3'b001;
    end
    finish_redirect(32'd64);
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 24) == 0) begin
        bus.redirect_pc = $urandom;
        start_redirect(bus.redirect_pc);
        finish_redirect(bus.redirect_pc);
      end
    end

    // Reset while a packet is held unaccepted
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(posedge clk); #1;
      found = bus.out_valid;
    end
    chk("rst_pending_reached", found, 1'b1);
    reset = 1'b0;
    load_program();
    @(negedge clk);
    #1 refill(32'd32);
    @(posedge clk); #1;
    reset = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("rst2_outputs", {bus.out_valid, bus.out_inst, bus.out_imm, bus.out_has_imm}, 34'd0);
    chk("rst2_addr", bus.imem_addr, 32'd32);
    @(negedge clk);
    chk("rst2_addr_next", bus.imem_addr, 32'd33);
    repeat (8) @(negedge clk);

    chk("traffic", pkt_cnt >= 100, 1'b1);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
